muxpga_cfg_sequencer: RTL and testbench

//   Host-side controller for the muxpga fabric. It drives the fabric's 8-bit pin bus on the

---
 rtl/muxpga_cfg_sequencer_if.sv | 34 +++
 rtl/muxpga_cfg_sequencer.sv | 113 +++++++++++
 tb/tb_muxpga_cfg_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muxpga_cfg_sequencer_if.sv
// Host and fabric-pin signal bundle for the muxpga configuration sequencer.
// master: host/fabric side driving stimulus; slave: the sequencer itself.
interface muxpga_cfg_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    // Host side
    logic             load_start;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_nibble;
    logic             run_start;
    logic [CNT_W-1:0] run_cycles;
    logic [3:0]       run_data;
    logic             busy;
    logic             loaded;
    logic             cfg_err;
    logic             done;
    logic [7:0]       result;
    // Fabric pins
    logic             fab_reset;
    logic [1:0]       fab_cmd;
    logic [3:0]       fab_nibble;
    logic [7:0]       fab_out;

    modport master (
        output load_start, cfg_valid, cfg_nibble, run_start, run_cycles, run_data, fab_out,
        input  cfg_ready, busy, loaded, cfg_err, done, result, fab_reset, fab_cmd, fab_nibble
    );

    modport slave (
        input  load_start, cfg_valid, cfg_nibble, run_start, run_cycles, run_data, fab_out,
        output cfg_ready, busy, loaded, cfg_err, done, result, fab_reset, fab_cmd, fab_nibble
    );
endinterface

// File: rtl/muxpga_cfg_sequencer.sv
// Host-side controller for the muxpga fabric: shifts in a configuration, verifies it by
// reading back the first nibble, then runs N enabled evaluation cycles and captures fab_out.
// Every output, including all fabric pins, is a register.
module muxpga_cfg_sequencer #(
    parameter int unsigned NIBBLES  = 24,
    parameter int unsigned CNT_W    = 8,
    parameter logic [1:0]  HOLD_CMD = 2'd2
) (
    input logic                  clk,
    input logic                  reset,
    muxpga_cfg_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(NIBBLES + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StVerify, StLoaded, StRun} state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [3:0]       first_q;
    logic             verify_q;  // second VERIFY cycle
    logic [CNT_W-1:0] run_cnt_q; // enabled cycles still to issue, including current

    // Single sequencer FSM; fabric pins show decisions one cycle after they are made.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            count_q        <= '0;
            first_q        <= '0;
            verify_q       <= 1'b0;
            run_cnt_q      <= '0;
            bus.cfg_ready  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.loaded     <= 1'b0;
            bus.cfg_err    <= 1'b0;
            bus.done       <= 1'b0;
            bus.result     <= '0;
            bus.fab_reset  <= 1'b1;
            bus.fab_cmd    <= HOLD_CMD;
            bus.fab_nibble <= '0;
        end else begin
            bus.fab_reset <= 1'b0;
            bus.done      <= 1'b0;
            case (state_q)
                StIdle, StLoaded: begin
                    bus.fab_cmd <= HOLD_CMD;
                    // Load has priority over run when both start pulses coincide.
                    if (bus.load_start) begin
                        state_q       <= StLoad;
                        count_q       <= '0;
                        bus.loaded    <= 1'b0;
                        bus.cfg_err   <= 1'b0;
                        bus.fab_reset <= 1'b1;
                        bus.cfg_ready <= 1'b1;
                        bus.busy      <= 1'b1;
                    end else if (bus.run_start && state_q == StLoaded) begin
                        if (bus.run_cycles == '0) begin
                            bus.done <= 1'b1;
                        end else begin
                            state_q        <= StRun;
                            run_cnt_q      <= bus.run_cycles;
                            bus.busy       <= 1'b1;
                            bus.fab_cmd    <= 2'd1;
                            bus.fab_nibble <= bus.run_data;
                        end
                    end
                end
                StLoad: begin
                    if (bus.cfg_valid && bus.cfg_ready) begin
                        bus.fab_cmd    <= 2'd0;
                        bus.fab_nibble <= bus.cfg_nibble;
                        count_q        <= count_q + CW'(1);
                        if (count_q == '0) begin
                            first_q <= bus.cfg_nibble;
                        end
                        if (count_q == CW'(NIBBLES - 1)) begin
                            bus.cfg_ready <= 1'b0;
                            verify_q      <= 1'b0;
                            state_q       <= StVerify;
                        end
                    end else begin
                        bus.fab_cmd <= HOLD_CMD;
                    end
                end
                StVerify: begin
                    bus.fab_cmd <= HOLD_CMD;
                    verify_q    <= 1'b1;
                    // Last shift lands at the end of the first VERIFY cycle, so read back in the 2nd.
                    if (verify_q) begin
                        if (bus.fab_out[7:4] != first_q) begin
                            bus.cfg_err <= 1'b1;
                        end
                        bus.loaded <= 1'b1;
                        bus.busy   <= 1'b0;
                        state_q    <= StLoaded;
                    end
                end
                StRun: begin
                    bus.result <= bus.fab_out;
                    if (run_cnt_q == CNT_W'(1)) begin
                        bus.fab_cmd <= HOLD_CMD;
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        state_q     <= StLoaded;
                    end else begin
                        run_cnt_q      <= run_cnt_q - CNT_W'(1);
                        bus.fab_nibble <= bus.run_data;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_muxpga_cfg_sequencer.sv
// Self-checking bench for muxpga_cfg_sequencer with a simple fabric model and a scoreboard.
module tb_muxpga_cfg_sequencer;
    localparam int NIB = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muxpga_cfg_sequencer_if #(.CNT_W(8)) bus ();

    muxpga_cfg_sequencer #(
        .NIBBLES  (NIB),
        .CNT_W    (8),
        .HOLD_CMD (2'd2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Fabric model: 24-deep config shift chain (cmd 0), accumulator state (cmd 1).
    // Readback shows cell_cfg[23] in the high nibble, corrupted to F when it holds 3.
    logic [3:0] cell_cfg [NIB];
    logic [7:0] fab_state = 8'h00;
    initial foreach (cell_cfg[i]) cell_cfg[i] = 4'h0;

    always @(posedge clk) begin
        if (bus.fab_cmd == 2'd0) begin
            for (int i = NIB - 1; i > 0; i--) cell_cfg[i] <= cell_cfg[i-1];
            cell_cfg[0] <= bus.fab_nibble;
        end
        if (bus.fab_reset) fab_state <= 8'h00;
        else if (bus.fab_cmd == 2'd1) fab_state <= fab_state + {bus.fab_nibble, cell_cfg[0]};
    end

    assign bus.fab_out = (bus.fab_cmd == 2'd1) ? fab_state :
                         (cell_cfg[NIB-1] == 4'h3) ? 8'hF0 : {cell_cfg[NIB-1], 4'h0};

    // Scoreboard
    typedef struct {
        int         n;
        logic [7:0] res;
        logic [3:0] data;
    } run_t;

    logic [3:0] exp_nib[$];
    logic       exp_load[$];
    run_t       exp_run[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: accumulator contents and last captured result, in spec terms.
    logic [7:0] model_state = 8'h00;
    logic [7:0] last_result = 8'h00;
    logic [3:0] last_nib    = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected (t=%0t)", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents a shift, run cycle, done or load.
    int   run_seen    = 0;
    logic loaded_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            run_seen    = 0;
            loaded_prev = 1'b0;
        end else begin
            if (bus.fab_cmd == 2'd0) begin
                if (exp_nib.size() == 0) unexpected("shift");
                else chk("shift_nibble", 32'(bus.fab_nibble), 32'(exp_nib.pop_front()));
            end
            if (bus.fab_cmd == 2'd1) begin
                if (exp_run.size() == 0) unexpected("run_cycle");
                else begin
                    run_seen++;
                    chk("run_nibble", 32'(bus.fab_nibble), 32'(exp_run[0].data));
                end
            end
            if (bus.done) begin
                if (exp_run.size() == 0) unexpected("done");
                else begin
                    run_t r;
                    r = exp_run.pop_front();
                    chk("run_enabled_cycles", 32'(run_seen), 32'(r.n));
                    chk("run_result", 32'(bus.result), 32'(r.res));
                    run_seen = 0;
                end
            end
            if (bus.loaded && !loaded_prev) begin
                if (exp_load.size() == 0) unexpected("loaded");
                else chk("cfg_err", 32'(bus.cfg_err), 32'(exp_load.pop_front()));
            end
            loaded_prev = bus.loaded;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] out_vec();
        return {bus.cfg_ready, bus.busy, bus.loaded, bus.cfg_err, bus.done, bus.result,
                bus.fab_reset, bus.fab_cmd, bus.fab_nibble};
    endfunction

    localparam logic [18:0] RESET_VEC = {5'b0, 8'h00, 1'b1, 2'd2, 4'h0};

    // Synchronous reset pulse applied after the monitor has sampled the current cycle.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("reset_outputs", 32'(out_vec()), 32'(RESET_VEC));
        chk("reset_nib_queue", 32'(exp_nib.size()), 0);
        model_state = 8'h00;
        last_result = 8'h00;
        #1;
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("fab_reset_release", 32'(bus.fab_reset), 0);
        tick();
    endtask

    // mode 0: nibbles 0..n-1; mode 1: first nibble 3; mode 2: first nibble never 3; 3: random.
    task automatic load_cfg(input int mode, input int n_offer, input bit with_run,
                            input bit abort10);
        logic [3:0] nibs[$];
        int i = 0, acc = 0, post = 0;
        bit full_seen = 0;
        for (int k = 0; k < n_offer; k++) begin
            logic [31:0] v;
            v = (mode == 0) ? 32'(k) : $urandom;
            nibs.push_back(v[3:0]);
        end
        if (mode == 1) nibs[0] = 4'h3;
        if (mode == 2) nibs[0] = 4'($urandom_range(4, 15));

        bus.load_start = 1'b1;
        bus.run_start  = with_run;
        bus.run_cycles = 8'd3;
        tick();
        bus.load_start = 1'b0;
        bus.run_start  = 1'b0;
        @(negedge clk);
        // {loaded, cfg_err, busy, cfg_ready, fab_reset}
        chk("load_entry", 32'({bus.loaded, bus.cfg_err, bus.busy, bus.cfg_ready, bus.fab_reset}),
            32'(5'b00111));
        tick();

        for (int c = 0; c < 400; c++) begin
            if (i >= n_offer) break;
            if (abort10 && acc == 10) break;
            if (full_seen && post >= 8) break;
            bus.cfg_valid  = ($urandom_range(0, 3) != 0);
            bus.cfg_nibble = nibs[i];
            bus.run_start  = (c == 4);
            @(negedge clk);
            if (full_seen) begin
                chk("ready_after_full", 32'(bus.cfg_ready), 0);
                post++;
            end
            if (bus.cfg_valid && bus.cfg_ready) begin
                exp_nib.push_back(nibs[i]);
                i++;
                acc++;
                if (acc == NIB) begin
                    full_seen = 1;
                    exp_load.push_back(nibs[0] == 4'h3);
                end
            end
            tick();
        end
        bus.cfg_valid = 1'b0;
        bus.run_start = 1'b0;
        if (abort10) return;

        chk("accept_count", 32'(acc), 32'(NIB));
        @(negedge clk);
        chk("ready_drop", 32'(bus.cfg_ready), 0);
        tick();
        begin
            bit got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bus.loaded) begin
                    got = 1;
                    break;
                end
                tick();
            end
            chk("loaded_seen", 32'(got), 1);
            tick();
        end
        chk("nib_queue_drained", 32'(exp_nib.size()), 0);
        model_state = 8'h00;
        last_nib    = nibs[NIB-1];
    endtask

    task automatic do_run(input int n, input logic [3:0] d);
        run_t r;
        logic [7:0] inc;
        int k;
        inc = {d, last_nib};
        if (n == 0) begin
            r.res = last_result;
        end else begin
            r.res       = 8'(int'(model_state) + (n - 1) * int'(inc));
            model_state = 8'(int'(model_state) + n * int'(inc));
            last_result = r.res;
        end
        r.n    = n;
        r.data = d;
        exp_run.push_back(r);

        bus.run_data   = d;
        bus.run_cycles = 8'(n);
        bus.run_start  = 1'b1;
        tick();
        bus.run_start = 1'b0;
        for (k = 1; k <= n + 5; k++) begin
            @(negedge clk);
            if (bus.done) break;
            tick();
        end
        chk("done_latency", 32'(k), 32'(n + 1));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_start = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_nibble = 4'h0;
        bus.run_start  = 1'b0;
        bus.run_cycles = 8'd0;
        bus.run_data   = 4'h0;

        repeat (3) tick();
        do_reset();

        // Run with no config is ignored
        bus.run_cycles = 8'd2;
        bus.run_start  = 1'b1;
        tick();
        bus.run_start = 1'b0;
        @(negedge clk);
        chk("idle_run_ignored", 32'({bus.done, bus.busy, bus.fab_cmd}), 32'({2'b00, 2'd2}));
        repeat (3) tick();

        load_cfg(0, NIB, 0, 0);
        do_run(3, 4'hA);
        do_run(0, 4'h5);

        load_cfg(1, NIB, 0, 0);           // readback corrupted -> cfg_err
        do_run(2, 4'h7);
        load_cfg(2, NIB, 0, 0);           // clears cfg_err
        load_cfg(2, NIB + 1, 0, 0);       // 25th nibble never accepted
        do_run(4, 4'hC);
        load_cfg(2, NIB, 1, 0);           // load_start + run_start together

        for (int it = 0; it < 5; it++) begin
            load_cfg(3, NIB, 0, 0);
            repeat (2) do_run($urandom_range(0, 12), 4'($urandom));
        end

        do_run(255, 4'h9);

        load_cfg(2, NIB, 0, 1);           // abort after 10 accepts
        do_reset();
        chk("loaded_after_reset", 32'(bus.loaded), 0);
        load_cfg(2, NIB, 0, 0);
        do_run(5, 4'h3);

        repeat (3) tick();
        chk("runs_pending", 32'(exp_run.size()), 0);
        chk("loads_pending", 32'(exp_load.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
